// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared opcode encodings, forwarding selects and hazard FSM states.
package hazard_ctrl_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_COM = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  typedef enum logic {ST_RUN, ST_MUL_BUSY} state_t;
endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: EX-stage operand forwarding selects; EX/MEM wins over MEM/WB, R0 never forwards.
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_wen_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_wen_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);
  logic mem_ok, wb_ok;
  assign mem_ok = mem_reg_wen_i && mem_rd_i != '0;
  assign wb_ok  = wb_reg_wen_i && wb_rd_i != '0;
  always_comb begin
    fwd_a_o = (mem_ok && mem_rd_i == ex_rs_i) ? FWD_EXM : (wb_ok && wb_rd_i == ex_rs_i) ? FWD_MWB : FWD_RF;
    fwd_b_o = (mem_ok && mem_rd_i == ex_rt_i) ? FWD_EXM : (wb_ok && wb_rd_i == ex_rt_i) ? FWD_MWB : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing (MUL occupancy, load-use, taken branch),
// forwarding selects and saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [3:0]        ex_op,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wen,
  input  logic              ex_mem_ren,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_wen,
  input  logic              ex_branch_taken,
  input  logic              cnt_clr,
  output logic              pc_wen,
  output logic              pc_src,
  output logic              if_id_wen,
  output logic              if_id_flush,
  output logic              id_ex_wen,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mul_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [3:0] MCNT_INIT = (MUL_CYCLES >= 2) ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic mul_stall, lu_stall, stall;
  logic unused;

  assign unused = ex_reg_wen;

  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    mul_stall = 1'b0;
    if (state_q == ST_RUN) begin
      if (ex_op == OP_MUL && MUL_CYCLES >= 2) begin
        mul_stall = 1'b1;
        mcnt_d    = MCNT_INIT;
        state_d   = ST_MUL_BUSY;
      end
    end else if (mcnt_q != '0) begin
      mul_stall = 1'b1;
      mcnt_d    = mcnt_q - 4'd1;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Gating with rst_n drops a MUL stall the moment reset is asserted, even if EX holds a MUL.
  assign lu_stall = state_q == ST_RUN && ex_mem_ren && ex_rd != '0 &&
                    (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  assign stall = !ex_branch_taken && ((mul_stall && rst_n) || lu_stall);

  always_comb begin
    pc_wen       = 1'b1;
    pc_src       = 1'b0;
    if_id_wen    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_wen    = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mul_busy     = 1'b0;
    if (ex_branch_taken) begin
      pc_src      = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mul_stall && rst_n) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_flush = 1'b1;
      mul_busy     = 1'b1;
    end else if (lu_stall) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = cnt_clr ? '0 : (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = cnt_clr ? '0 : (ex_branch_taken && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      mcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .ex_rs_i      (ex_rs),
    .ex_rt_i      (ex_rt),
    .mem_rd_i     (mem_rd),
    .mem_reg_wen_i(mem_reg_wen),
    .wb_rd_i      (wb_rd),
    .wb_reg_wen_i (wb_reg_wen),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b)
  );
endmodule
